// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: drives IorD/mem_wr, waits out read latency, extracts byte/half loads,
// and merges byte/half stores into the read word before writing back.
module mem_access_ctrl #(
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic [2:0]  req_src,
  input  logic [31:0] store_data,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  IorD,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        err
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [2:0] K_FETCH = 3'b000;
  localparam logic [2:0] K_LW    = 3'b001;
  localparam logic [2:0] K_LHU   = 3'b010;
  localparam logic [2:0] K_LBU   = 3'b011;
  localparam logic [2:0] K_SW    = 3'b100;
  localparam logic [2:0] K_SH    = 3'b101;
  localparam logic [2:0] K_SB    = 3'b110;
  localparam logic [2:0] K_VEC   = 3'b111;

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  kind_q, kind_d;
  logic [31:0] sdata_q, sdata_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  iord_q, iord_d;
  logic        mem_wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_q, rd_d;
  logic        done_d, err_d;
  logic        done_q, err_q, mem_wr_q;

  logic [2:0]  src_sel;
  logic        src_bad;
  logic        misaligned;
  logic [31:0] merged;
  logic [31:0] extracted;

  // Fetch and vector reads have fixed address sources regardless of req_src.
  always_comb begin
    src_sel = req_src;
    if (req_kind == K_FETCH) src_sel = 3'b000;
    else if (req_kind == K_VEC) src_sel = 3'b001;
    src_bad = (req_kind != K_FETCH) && (req_kind != K_VEC) && (req_src > 3'd4);
  end

  always_comb begin
    misaligned = 1'b0;
    case (kind_q)
      K_LHU, K_SH: misaligned = addr_lo[0];
      K_LBU, K_SB: misaligned = 1'b0;
      default:     misaligned = (addr_lo != 2'b00);
    endcase
  end

  always_comb begin
    merged = mem_data_in;
    if (kind_q == K_SB) begin
      case (lane_q)
        2'd0:    merged[7:0]   = sdata_q[7:0];
        2'd1:    merged[15:8]  = sdata_q[7:0];
        2'd2:    merged[23:16] = sdata_q[7:0];
        default: merged[31:24] = sdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = sdata_q[15:0];
    end else begin
      merged[15:0] = sdata_q[15:0];
    end
  end

  always_comb begin
    extracted = mem_data_in;
    if (kind_q == K_LBU) begin
      case (lane_q)
        2'd0:    extracted = {24'h0, mem_data_in[7:0]};
        2'd1:    extracted = {24'h0, mem_data_in[15:8]};
        2'd2:    extracted = {24'h0, mem_data_in[23:16]};
        default: extracted = {24'h0, mem_data_in[31:24]};
      endcase
    end else if (kind_q == K_LHU) begin
      extracted = lane_q[1] ? {16'h0, mem_data_in[31:16]} : {16'h0, mem_data_in[15:0]};
    end
  end

  // Outputs are computed one state ahead so that they are registered alongside the state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    kind_d   = kind_q;
    sdata_d  = sdata_q;
    lane_d   = lane_q;
    iord_d   = iord_q;
    mem_wr_d = 1'b0;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        iord_d = 3'b000;
        if (req_valid) begin
          kind_d  = req_kind;
          sdata_d = store_data;
          if (src_bad) begin
            state_d = RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ADDR;
            iord_d  = src_sel;
          end
        end
      end
      ADDR: begin
        lane_d = addr_lo;
        if (misaligned) begin
          state_d = RESP;
          done_d  = 1'b1;
          err_d   = 1'b1;
          iord_d  = 3'b000;
        end else if (kind_q == K_SW) begin
          state_d  = WRITE;
          mem_wr_d = 1'b1;
          wdata_d  = sdata_q;
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (kind_q == K_SH || kind_q == K_SB) begin
            state_d  = WRITE;
            mem_wr_d = 1'b1;
            wdata_d  = merged;
          end else begin
            state_d = RESP;
            done_d  = 1'b1;
            rd_d    = extracted;
            iord_d  = 3'b000;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WRITE: begin
        state_d = RESP;
        done_d  = 1'b1;
        iord_d  = 3'b000;
      end
      default: begin
        state_d = IDLE;
        iord_d  = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      kind_q   <= 3'b000;
      sdata_q  <= 32'h0;
      lane_q   <= 2'b00;
      iord_q   <= 3'b000;
      mem_wr_q <= 1'b0;
      wdata_q  <= 32'h0;
      rd_q     <= 32'h0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
      sdata_q  <= sdata_d;
      lane_q   <= lane_d;
      iord_q   <= iord_d;
      mem_wr_q <= mem_wr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign IorD      = iord_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = wdata_q;
  assign rd_data   = rd_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
